somador_pipeline: RTL and testbench
===================================

Name: somador_pipeline

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshake on input and output.
- Operands are split into STAGES equal segments. Each pipeline stage adds one segment and registers its carry into the next stage, so ripple length per cycle is WIDTH/STAGES bits.
- Serves as the general arithmetic unit for the datapath, replacing fixed-width combinational ripple adders wherever width or timing requires it.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); segment width SEG = WIDTH/STAGES.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; add mode only.
- sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry-out of MSB. In sub mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the system):
  - All stage valid bits = 0; out_valid = 0; s = 0; cout = 0; ovf = 0.
  - in_ready = 1 once rst is low.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - When adv = 0, all stage registers hold (data and valid).
- Operand conditioning at capture:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1):
  - Adds segment k of a and b_eff plus the carry registered by stage k-1 (c0 for stage 0).
  - Registers the segment sum, the carry-out, and the remaining unprocessed upper segments.
  - Lower result segments already computed are carried forward unchanged (skew/deskew registers).
- Stage valid bit follows data. A bubble (in_valid = 0 while adv = 1) inserts valid = 0.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle while out_ready = 1.
- Output flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This is computed in the final stage from the top segment's internal carries.
- Wrap-around: s is modulo 2^WIDTH; no saturation.
- Simultaneous transfer in and out in the same cycle is legal and loses nothing.
- out_valid=1, out_ready=0: s/cout/ovf stable until the output transfer.
- STAGES = 1: single registered stage, latency 1.
- cin is ignored when sub = 1.
- Reset mid-operation: all in-flight results are discarded and no stale out_valid appears after reset.
- X on a/b/cin/sub while in_valid = 0 must not propagate to the outputs.

Decomposition:
- Package somador_pkg:
  - function seg_count(WIDTH, STAGES).
  - localparam-style helpers for SEG.
  - Elaboration check that WIDTH % STAGES == 0 and STAGES >= 1 (fatal otherwise).
- Sub-module somador_segmento: parametrised SEG-bit combinational ripple adder.
  - Outputs sum, carry-out, and carry into its MSB (for ovf).
  - One instance per stage, via a generate loop.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles: s=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0, sub=0 -> s=0x8000, cout=0, ovf=1.
  - Then a=0x0005, b=0x0007, sub=1, cin=1 -> s=0xFFFE, cout=0, ovf=0 (cin ignored).
- Stream of 8 random operand sets back-to-back, out_ready=0 on cycles 5-7:
  - in_ready drops while the output is held.
  - All 8 results match the reference model, in order, none dropped or duplicated.
  - s stable while stalled.
- Issue 3 ops, assert rst for 1 cycle at cycle 2:
  - out_valid=0 and s=0 immediately (asynchronous).
  - None of the 3 results ever appear.
  - A new op after reset completes in 4 cycles.
- Alternating in_valid 1/0 (bubbles) with out_ready=1 -> out_valid pattern replicates the input pattern delayed by 4 cycles.
- WIDTH=8, STAGES=1, and WIDTH=32, STAGES=8, 1000 random add/sub ops -> all s/cout/ovf match the model; latency 1 and 8 respectively.

Source files
------------

// File: rtl/somador_pkg.sv
// Shared helpers for the pipelined adder/subtractor: segment sizing and
// configuration legality.
package somador_pkg;

   // Width of the slice of the operands that each pipeline stage adds.
   function automatic int seg_count(input int width, input int stages);
      return width / stages;
   endfunction

   // Legal only when the word splits into equal, non-empty segments.
   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/somador_segmento.sv
// SEG-bit combinational ripple adder. Also exposes the carry entering the
// MSB so the owner can derive signed overflow.
module somador_segmento #(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] x,
   input  logic [SEG-1:0] y,
   input  logic           ci,
   output logic [SEG-1:0] sum,
   output logic           co,
   output logic           c_msb
);

   logic [SEG:0] c;

   // Bit-serial ripple through the segment.
   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = ci;
      for (int i = 0; i < SEG; i++) begin
         sum[i]   = x[i] ^ y[i] ^ c[i];
         c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co    = c[SEG];
   assign c_msb = c[SEG - 1];

endmodule

// File: rtl/somador_pipeline.sv
// Pipelined two's-complement adder/subtractor. Stage k adds segment k and
// hands its carry to stage k+1; unprocessed upper operand bits travel ahead
// (skew) and finished lower sum bits travel behind (deskew).
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// whole pipe advances together (adv = !out_valid || out_ready, in_ready = adv);
// when adv is low every stage holds data and valid, so a presented result
// stays stable until out_ready takes it.
module somador_pipeline
   import somador_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int SEG = seg_count(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $fatal(1, "somador_pipeline: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IW = WIDTH - k * SEG;  // operand bits still to add entering stage k
      localparam int DW = (k + 1) * SEG;    // result bits known leaving stage k

      logic [IW-1:0]  a_in;
      logic [IW-1:0]  b_in;
      logic           c_in;
      logic           v_in;
      logic [DW-1:0]  s_next;
      logic [SEG-1:0] seg_sum;
      logic           seg_co;
      logic [DW-1:0]  s_q;
      logic           c_q;
      logic           v_q;

      if (k == 0) begin : g_src
         // Subtraction is a + ~b + 1; cin only matters when adding.
         assign a_in   = a;
         assign b_in   = sub ? ~b : b;
         assign c_in   = sub | cin;
         assign v_in   = in_valid;
         assign s_next = seg_sum;
      end else begin : g_src
         assign a_in   = g_stage[k-1].g_mid.a_q;
         assign b_in   = g_stage[k-1].g_mid.b_q;
         assign c_in   = g_stage[k-1].c_q;
         assign v_in   = g_stage[k-1].v_q;
         assign s_next = {seg_sum, g_stage[k-1].s_q};
      end

      if (k == STAGES - 1) begin : g_top
         logic seg_cm;
         logic f_q;

         somador_segmento #(.SEG(SEG)) u_seg (
            .x     (a_in),
            .y     (b_in),
            .ci    (c_in),
            .sum   (seg_sum),
            .co    (seg_co),
            .c_msb (seg_cm)
         );

         // Signed overflow: carry into the word MSB differs from carry out.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)               f_q <= 1'b0;
            else if (adv && v_in) f_q <= seg_cm ^ seg_co;
         end
      end else begin : g_mid
         logic              cm_unused;  // only the top segment's MSB carry matters
         logic [IW-SEG-1:0] a_q;
         logic [IW-SEG-1:0] b_q;

         somador_segmento #(.SEG(SEG)) u_seg (
            .x     (a_in[SEG-1:0]),
            .y     (b_in[SEG-1:0]),
            .ci    (c_in),
            .sum   (seg_sum),
            .co    (seg_co),
            .c_msb (cm_unused)
         );

         // Skew registers: upper operand segments not yet added.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && v_in) begin
               a_q <= a_in[IW-1:SEG];
               b_q <= b_in[IW-1:SEG];
            end
         end
      end

      // Stage valid follows data; data loads only with a valid token so
      // undriven operands during bubbles never reach the result.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_in;
            if (v_in) begin
               s_q <= s_next;
               c_q <= seg_co;
            end
         end
      end
   end

   assign s         = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign out_valid = g_stage[STAGES-1].v_q;
   assign ovf       = g_stage[STAGES-1].g_top.f_q;

endmodule

// File: tb/tb_somador_pipeline.sv
// Bench for somador_pipeline: three configurations (16/4, 8/1, 32/8) share
// one driver, one scoreboard queue and one monitor through a selector.
module tb_somador_pipeline;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- shared stimulus ----------------
   logic [31:0] a_v, b_v;
   logic        cin_v, sub_v, in_valid, out_ready;
   int          sel;        // 0: 16/4, 1: 8/1, 2: 32/8
   int          rdy_mode;   // 0: always ready, 1: stall window, 2: random
   int          stall_lo, stall_hi;

   logic        iv16, iv8, iv32;
   assign iv16 = in_valid && (sel == 0);
   assign iv8  = in_valid && (sel == 1);
   assign iv32 = in_valid && (sel == 2);

   logic        rdy16, ov16, co16, of16;
   logic [15:0] s16;
   logic        rdy8, ov8, co8, of8;
   logic [7:0]  s8;
   logic        rdy32, ov32, co32, of32;
   logic [31:0] s32;

   somador_pipeline #(.WIDTH(16), .STAGES(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
      .a(a_v[15:0]), .b(b_v[15:0]), .cin(cin_v), .sub(sub_v),
      .out_valid(ov16), .out_ready(out_ready), .s(s16), .cout(co16), .ovf(of16));

   somador_pipeline #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
      .a(a_v[7:0]), .b(b_v[7:0]), .cin(cin_v), .sub(sub_v),
      .out_valid(ov8), .out_ready(out_ready), .s(s8), .cout(co8), .ovf(of8));

   somador_pipeline #(.WIDTH(32), .STAGES(8)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32),
      .a(a_v), .b(b_v), .cin(cin_v), .sub(sub_v),
      .out_valid(ov32), .out_ready(out_ready), .s(s32), .cout(co32), .ovf(of32));

   logic        mon_valid, mon_in_ready, mon_cout, mon_ovf;
   logic [31:0] mon_s;

   always_comb begin
      mon_valid    = ov16;
      mon_in_ready = rdy16;
      mon_s        = 32'(s16);
      mon_cout     = co16;
      mon_ovf      = of16;
      if (sel == 1) begin
         mon_valid = ov8;  mon_in_ready = rdy8;  mon_s = 32'(s8);
         mon_cout  = co8;  mon_ovf      = of8;
      end else if (sel == 2) begin
         mon_valid = ov32; mon_in_ready = rdy32; mon_s = s32;
         mon_cout  = co32; mon_ovf      = of32;
      end
   end

   function automatic int cur_w();
      return (sel == 0) ? 16 : ((sel == 1) ? 8 : 32);
   endfunction

   // ---------------- reference model ----------------
   // Plain integer arithmetic: {ovf, cout, s} for a w-bit add or subtract.
   function automatic logic [33:0] model(input int w, input logic [31:0] ua, input logic [31:0] ub,
                                         input logic ci, input logic sb);
      longint mask, half, x, y, sx, sy, r, sr;
      logic   co, ov;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      x    = longint'(ua) & mask;
      y    = longint'(ub) & mask;
      sx   = (x >= half) ? x - 2 * half : x;
      sy   = (y >= half) ? y - 2 * half : y;
      if (sb) begin
         r  = x - y;
         co = (x >= y);
         sr = sx - sy;
      end else begin
         r  = x + y + longint'(ci);
         co = ((r >> w) & 1) != 0;
         sr = sx + sy + longint'(ci);
      end
      ov = (sr >= half) || (sr < -half);
      return {ov, co, 32'(r & mask)};
   endfunction

   // ---------------- scoreboard ----------------
   logic [33:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int n_out = 0;
   int ready_low_cnt = 0;

   task automatic check_val(input string name, input logic [33:0] got, input logic [33:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- out_ready policy ----------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // in_ready observation (used to confirm back-pressure reaches the input)
   initial forever begin
      @(negedge clk);
      #1;
      if (!rst && !mon_in_ready) ready_low_cnt++;
   end

   // ---------------- monitor ----------------
   initial begin
      logic [33:0] held, got;
      bit          held_v;
      held_v = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            held_v = 1'b0;
         end else begin
            got = {mon_ovf, mon_cout, mon_s};
            if (held_v && mon_valid) check_val("hold_stable", got, held);
            held_v = 1'b0;
            if (mon_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %h expected no result (t=%0t)", got, $time);
               end else begin
                  check_val("result", got, exp_q.pop_front());
                  n_out++;
               end
            end else if (mon_valid) begin
               held   = got;
               held_v = 1'b1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                       input logic sb, input bit push);
      int guard;
      @(negedge clk);
      a_v = av; b_v = bv; cin_v = ci; sub_v = sb; in_valid = 1'b1;
      #1;
      guard = 0;
      while (!mon_in_ready && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!mon_in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      end else if (push) begin
         exp_q.push_back(model(cur_w(), av, bv, ci, sb));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_v = 'x; b_v = 'x; cin_v = 1'bx; sub_v = 1'bx;
   endtask

   task automatic check_latency(input int exp_lat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #3;
         n++;
      end while (!mon_valid && n < 100);
      check_val("latency", 34'(n), 34'(exp_lat));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_valid) && n < 3000) begin
         @(negedge clk);
         #3;
         n++;
      end
      check_val("drained", 34'(exp_q.size()), 34'(0));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      bit pat[24];
      int low0, out0;

      rst = 1'b1; in_valid = 1'b0; sel = 0; rdy_mode = 0;
      stall_lo = 0; stall_hi = -1;
      a_v = 'x; b_v = 'x; cin_v = 1'bx; sub_v = 1'bx;

      // reset state
      repeat (2) @(posedge clk);
      #2;
      check_val("rst_out_valid", 34'(mon_valid), 34'(0));
      check_val("rst_flags_s", {mon_ovf, mon_cout, mon_s}, 34'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_in_ready", 34'(mon_in_ready), 34'(1));

      // directed adds/subtracts with latency
      send(32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b1);
      check_latency(4);
      drain();
      send(32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b1);
      check_latency(4);
      drain();
      send(32'h0005, 32'h0007, 1'b1, 1'b1, 1'b1);
      check_latency(4);
      drain();

      // back-to-back stream with a 3-cycle output stall
      low0 = ready_low_cnt;
      out0 = n_out;
      stall_lo = cyc + 6;
      stall_hi = cyc + 8;
      rdy_mode = 1;
      for (int i = 0; i < 8; i++)
         send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      drain();
      check_val("in_ready_dropped", 34'(ready_low_cnt > low0), 34'(1));
      check_val("stream_count", 34'(n_out - out0), 34'(8));
      rdy_mode = 0;

      // reset in the middle of three in-flight operations
      for (int i = 0; i < 3; i++)
         send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      #1;
      rst = 1'b1;
      #1;
      check_val("midrst_out_valid", 34'(mon_valid), 34'(0));
      check_val("midrst_flags_s", {mon_ovf, mon_cout, mon_s}, 34'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      send(32'h1234, 32'h4321, 1'b1, 1'b0, 1'b1);
      check_latency(4);
      drain();

      // bubbles: out_valid must echo the input pattern four cycles later
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         pat[i] = (i < 16) && (i % 2 == 0);
         if (pat[i]) begin
            a_v = $urandom; b_v = $urandom;
            cin_v = 1'($urandom_range(0, 1)); sub_v = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            exp_q.push_back(model(cur_w(), a_v, b_v, cin_v, sub_v));
         end else begin
            in_valid = 1'b0;
            a_v = 'x; b_v = 'x; cin_v = 1'bx; sub_v = 1'bx;
         end
         #3;
         if (i >= 4) check_val("bubble_pattern", 34'(mon_valid), 34'(pat[i - 4]));
      end
      in_valid = 1'b0;
      drain();

      // other configurations: latency then 1000 random ops under random back-pressure
      for (int cfg = 1; cfg <= 2; cfg++) begin
         @(negedge clk);
         sel = cfg;
         rdy_mode = 0;
         send($urandom, $urandom, 1'b1, 1'b0, 1'b1);
         check_latency((cfg == 1) ? 1 : 8);
         drain();
         rdy_mode = 2;
         for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
         end
         rdy_mode = 0;
         drain();
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
